alu_multicycle_m: RTL

- Execute-stage ALU directly downstream of the register file / ALUSrc mux; consumes data1 and data2, where data2 is either a register or the immediate.
- Single-cycle logic/arithmetic ops complete with a registered 1-cycle latency.
- MUL runs as an iterative shift-add over WIDTH cycles under a start/busy/done handshake.
- Result and flags feed the writeback path (writeData) and the branch logic (zero flag).

---
 rtl/alu_multicycle_m_if.sv | 27 ++
 rtl/alu_multicycle_m.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle_m_if.sv
// Execute-stage ALU handshake/operand bundle: request side (start, op, operands)
// and response side (registered result, flags, busy/done).
interface alu_multicycle_m_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [3:0]       alu_control;
   logic [WIDTH-1:0] data1;
   logic [WIDTH-1:0] data2;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             negative;
   logic             carry;
   logic             overflow;
   logic             busy;
   logic             done;

   modport master (
      output start, alu_control, data1, data2,
      input  result, zero, negative, carry, overflow, busy, done
   );

   modport slave (
      input  start, alu_control, data1, data2,
      output result, zero, negative, carry, overflow, busy, done
   );
endinterface

// File: rtl/alu_multicycle_m.sv
// Multi-cycle execute ALU: registered single-cycle logic/arith ops, iterative shift-add MUL.
// Define ALU_UDIV_EN to add an unsigned restoring divider on alu_control=1001.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for start; single-cycle ops finish here
// MUL_RUN | shift-add multiply, WIDTH iterations
// DIV_RUN | restoring divide, WIDTH iterations (ALU_UDIV_EN)
module alu_multicycle_m #(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          reset_n,
   alu_multicycle_m_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_ORR  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_PASS = 4'b0111;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_MUL  = 4'b1000;
`ifdef ALU_UDIV_EN
   localparam logic [3:0] OP_UDIV = 4'b1001;
`endif

   typedef enum logic [1:0] {
`ifdef ALU_UDIV_EN
      DIV_RUN = 2'd2,
`endif
      IDLE    = 2'd0,
      MUL_RUN = 2'd1
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] acc, acc_nxt;
   logic [WIDTH-1:0] mcand, mcand_nxt;
   logic [WIDTH-1:0] mplier, mplier_nxt;
   logic [WIDTH-1:0] result_q, result_nxt;
   logic             zero_q, zero_nxt;
   logic             neg_q, neg_nxt;
   logic             carry_q, carry_nxt;
   logic             ovf_q, ovf_nxt;
   logic             busy_q, busy_nxt;
   logic             done_q, done_nxt;

   logic             finish;
   logic [WIDTH-1:0] fin_res;
   logic             fin_c, fin_v;

   logic [WIDTH:0]   sum_ext, diff_ext;
   logic [WIDTH-1:0] acc_add;
   logic [CNT_W-1:0] cnt_inc;
   logic             a_msb, b_msb;

   assign a_msb    = bus.data1[WIDTH-1];
   assign b_msb    = bus.data2[WIDTH-1];
   assign sum_ext  = {1'b0, bus.data1} + {1'b0, bus.data2};
   assign diff_ext = {1'b0, bus.data1} + {1'b0, ~bus.data2} + {{WIDTH{1'b0}}, 1'b1};
   assign acc_add  = mplier[0] ? (acc + mcand) : acc;
   assign cnt_inc  = cnt + CNT_W'(1);

`ifdef ALU_UDIV_EN
   // acc holds the partial remainder, mcand the divisor, mplier shifts dividend out / quotient in.
   logic [WIDTH:0]   rem_sh, rem_sub;
   logic             q_bit;
   assign rem_sh  = {acc, mplier[WIDTH-1]};
   assign rem_sub = rem_sh - {1'b0, mcand};
   assign q_bit   = ~rem_sub[WIDTH];
`endif

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      acc_nxt    = acc;
      mcand_nxt  = mcand;
      mplier_nxt = mplier;
      busy_nxt   = busy_q;
      done_nxt   = 1'b0;
      finish     = 1'b0;
      fin_res    = '0;
      fin_c      = 1'b0;
      fin_v      = 1'b0;

      case (state)
         IDLE: begin
            if (bus.start) begin
               case (bus.alu_control)
                  OP_MUL: begin
                     state_nxt  = MUL_RUN;
                     busy_nxt   = 1'b1;
                     cnt_nxt    = '0;
                     acc_nxt    = '0;
                     mcand_nxt  = bus.data1;
                     mplier_nxt = bus.data2;
                  end
`ifdef ALU_UDIV_EN
                  OP_UDIV: begin
                     if (bus.data2 == '0) begin
                        finish = 1'b1;
                     end else begin
                        state_nxt  = DIV_RUN;
                        busy_nxt   = 1'b1;
                        cnt_nxt    = '0;
                        acc_nxt    = '0;
                        mcand_nxt  = bus.data2;
                        mplier_nxt = bus.data1;
                     end
                  end
`endif
                  OP_AND:  begin finish = 1'b1; fin_res = bus.data1 & bus.data2; end
                  OP_ORR:  begin finish = 1'b1; fin_res = bus.data1 | bus.data2; end
                  OP_PASS: begin finish = 1'b1; fin_res = bus.data2; end
                  OP_NOR:  begin finish = 1'b1; fin_res = ~(bus.data1 | bus.data2); end
                  OP_ADD: begin
                     finish  = 1'b1;
                     fin_res = sum_ext[WIDTH-1:0];
                     fin_c   = sum_ext[WIDTH];
                     fin_v   = (a_msb == b_msb) && (sum_ext[WIDTH-1] != a_msb);
                  end
                  OP_SUB: begin
                     finish  = 1'b1;
                     fin_res = diff_ext[WIDTH-1:0];
                     fin_c   = diff_ext[WIDTH];
                     fin_v   = (a_msb != b_msb) && (diff_ext[WIDTH-1] != a_msb);
                  end
                  default: finish = 1'b1;
               endcase
            end
         end

         MUL_RUN: begin
            acc_nxt    = acc_add;
            mcand_nxt  = mcand << 1;
            mplier_nxt = mplier >> 1;
            cnt_nxt    = cnt_inc;
            if (cnt_inc == CNT_W'(WIDTH)) begin
               finish    = 1'b1;
               fin_res   = acc_add;
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
            end
         end

`ifdef ALU_UDIV_EN
         DIV_RUN: begin
            acc_nxt    = q_bit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            mplier_nxt = {mplier[WIDTH-2:0], q_bit};
            cnt_nxt    = cnt_inc;
            if (cnt_inc == CNT_W'(WIDTH)) begin
               finish    = 1'b1;
               fin_res   = {mplier[WIDTH-2:0], q_bit};
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
            end
         end
`endif

         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
      endcase

      result_nxt = result_q;
      zero_nxt   = zero_q;
      neg_nxt    = neg_q;
      carry_nxt  = carry_q;
      ovf_nxt    = ovf_q;
      if (finish) begin
         result_nxt = fin_res;
         zero_nxt   = (fin_res == '0);
         neg_nxt    = fin_res[WIDTH-1];
         carry_nxt  = fin_c;
         ovf_nxt    = fin_v;
         done_nxt   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         acc      <= acc_nxt;
         mcand    <= mcand_nxt;
         mplier   <= mplier_nxt;
         result_q <= result_nxt;
         zero_q   <= zero_nxt;
         neg_q    <= neg_nxt;
         carry_q  <= carry_nxt;
         ovf_q    <= ovf_nxt;
         busy_q   <= busy_nxt;
         done_q   <= done_nxt;
      end
   end

   assign bus.result   = result_q;
   assign bus.zero     = zero_q;
   assign bus.negative = neg_q;
   assign bus.carry    = carry_q;
   assign bus.overflow = ovf_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
endmodule
